// File: rtl/riscv_cust_insn_encoder_pkg.sv
// Shared definitions for the custom STR_OPS / MAC_OPS instruction encoder.
package riscv_cust_insn_encoder_pkg;

  localparam int INSN_WIDTH     = 32;
  localparam int OPCODE_WIDTH   = 7;
  localparam int FUNCT3_WIDTH   = 3;
  localparam int FUNCT7_WIDTH   = 7;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [OPCODE_WIDTH-1:0] OPCODE_STR_OPS = 7'h0b;
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_MAC_OPS = 7'h2b;

  // STR sub-ops occupy funct3[1:0]; funct3[2] must be zero
  localparam logic [1:0] STR_OP_UPPER = 2'd0;
  localparam logic [1:0] STR_OP_LOWER = 2'd1;
  localparam logic [1:0] STR_OP_REV   = 2'd2;
  localparam logic [1:0] STR_OP_LEN   = 2'd3;

  // MAC sub-ops; 3'b111 is unassigned and therefore illegal
  localparam logic [FUNCT3_WIDTH-1:0] MAC_OP   = 3'd0;
  localparam logic [FUNCT3_WIDTH-1:0] MUL_OP   = 3'd1;
  localparam logic [FUNCT3_WIDTH-1:0] CON_OP   = 3'd2;
  localparam logic [FUNCT3_WIDTH-1:0] ACC_OP   = 3'd3;
  localparam logic [FUNCT3_WIDTH-1:0] CLR_OP   = 3'd4;
  localparam logic [FUNCT3_WIDTH-1:0] W_RD_OP  = 3'd5;
  localparam logic [FUNCT3_WIDTH-1:0] W_WB_OP  = 3'd6;

  typedef enum logic {CUST_STR, CUST_MAC} cust_class_e;

  typedef enum logic [0:0] {ST_IDLE, ST_EMIT} enc_state_e;

  // Register index step used while walking a burst: 31 wraps to 1 so x0 is never produced
  function automatic logic [REG_ADDR_WIDTH-1:0] reg_inc(input logic [REG_ADDR_WIDTH-1:0] x);
    return (x == 5'd31) ? 5'd1 : x + 5'd1;
  endfunction

endpackage

// File: rtl/riscv_cust_insn_encoder_pack.sv
// Combinational R-type packer for the custom instruction classes, with legality flag.
module riscv_cust_insn_pack
  import riscv_cust_insn_encoder_pkg::*;
(
  input  cust_class_e                cls,
  input  logic [FUNCT3_WIDTH-1:0]    op,
  input  logic [REG_ADDR_WIDTH-1:0]  rd,
  input  logic [REG_ADDR_WIDTH-1:0]  rs1,
  input  logic [REG_ADDR_WIDTH-1:0]  rs2,
  output logic [INSN_WIDTH-1:0]      word,
  output logic                       illegal
);

  logic [OPCODE_WIDTH-1:0] opcode;

  // Select opcode, flag unassigned sub-ops, and assemble the word
  always_comb begin
    if (cls == CUST_STR) begin
      opcode  = OPCODE_STR_OPS;
      illegal = op[2];
    end else begin
      opcode  = OPCODE_MAC_OPS;
      illegal = (op == 3'b111);
    end
    word = {{FUNCT7_WIDTH{1'b0}}, rs2, rs1, op, rd, opcode};
  end

endmodule

// File: rtl/riscv_cust_insn_encoder.sv
// Request-to-instruction-stream encoder: expands one request into a burst of
// R-type words that walk rd/rs1, with a registered output and no bubble between bursts.
module riscv_cust_insn_encoder
  import riscv_cust_insn_encoder_pkg::*;
#(
  parameter int REP_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_class,
  input  logic [FUNCT3_WIDTH-1:0]    req_op,
  input  logic [REG_ADDR_WIDTH-1:0]  req_rd,
  input  logic [REG_ADDR_WIDTH-1:0]  req_rs1,
  input  logic [REG_ADDR_WIDTH-1:0]  req_rs2,
  input  logic [REP_W-1:0]           req_repeat,
  output logic                       insn_valid,
  input  logic                       insn_ready,
  output logic [INSN_WIDTH-1:0]      insn_rdata,
  output logic                       insn_last,
  output logic                       illegal_o
);

  enc_state_e                  state_q, state_d;
  logic [REP_W-1:0]            cnt_q, cnt_d;
  cust_class_e                 class_q, class_d;
  logic [FUNCT3_WIDTH-1:0]     op_q, op_d;
  logic [REG_ADDR_WIDTH-1:0]   rd_q, rd_d;
  logic [REG_ADDR_WIDTH-1:0]   rs1_q, rs1_d;
  logic [REG_ADDR_WIDTH-1:0]   rs2_q, rs2_d;
  logic                        insn_valid_q, insn_valid_d;
  logic [INSN_WIDTH-1:0]       insn_rdata_q, insn_rdata_d;
  logic                        insn_last_q, insn_last_d;
  logic                        illegal_q, illegal_d;

  logic                        insn_fire;
  logic                        burst_end;
  logic                        req_fire;

  cust_class_e                 pk_class;
  logic [FUNCT3_WIDTH-1:0]     pk_op;
  logic [REG_ADDR_WIDTH-1:0]   pk_rd, pk_rs1, pk_rs2;
  logic [INSN_WIDTH-1:0]       pk_word;
  logic                        pk_illegal;

  // A new request is taken when idle, or on the cycle the final word of a burst is consumed
  always_comb begin
    insn_fire = insn_valid_q & insn_ready;
    burst_end = (state_q == ST_EMIT) & insn_fire & (cnt_q == '0);
    req_ready = (state_q == ST_IDLE) | burst_end;
    req_fire  = req_valid & req_ready;
  end

  // One packer serves both a fresh request and the next step of a running burst
  always_comb begin
    pk_class = req_fire ? cust_class_e'(req_class) : class_q;
    pk_op    = req_fire ? req_op  : op_q;
    pk_rs2   = req_fire ? req_rs2 : rs2_q;
    pk_rd    = req_fire ? req_rd  : reg_inc(rd_q);
    pk_rs1   = req_fire ? req_rs1 : reg_inc(rs1_q);
  end

  riscv_cust_insn_pack u_pack (
    .cls     (pk_class),
    .op      (pk_op),
    .rd      (pk_rd),
    .rs1     (pk_rs1),
    .rs2     (pk_rs2),
    .word    (pk_word),
    .illegal (pk_illegal)
  );

  // Next-state: request load, burst step, burst end; everything holds under backpressure
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    class_d      = class_q;
    op_d         = op_q;
    rd_d         = rd_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    insn_valid_d = insn_valid_q;
    insn_rdata_d = insn_rdata_q;
    insn_last_d  = insn_last_q;
    illegal_d    = 1'b0;

    if (req_fire) begin
      if (pk_illegal) begin
        state_d      = ST_IDLE;
        insn_valid_d = 1'b0;
        insn_last_d  = 1'b0;
        illegal_d    = 1'b1;
      end else begin
        state_d      = ST_EMIT;
        cnt_d        = req_repeat;
        class_d      = pk_class;
        op_d         = pk_op;
        rd_d         = pk_rd;
        rs1_d        = pk_rs1;
        rs2_d        = pk_rs2;
        insn_valid_d = 1'b1;
        insn_rdata_d = pk_word;
        insn_last_d  = (req_repeat == '0);
      end
    end else if ((state_q == ST_EMIT) && insn_fire) begin
      if (cnt_q != '0) begin
        cnt_d        = cnt_q - REP_W'(1);
        rd_d         = pk_rd;
        rs1_d        = pk_rs1;
        insn_rdata_d = pk_word;
        insn_last_d  = (cnt_q == REP_W'(1));
      end else begin
        state_d      = ST_IDLE;
        insn_valid_d = 1'b0;
        insn_last_d  = 1'b0;
      end
    end
  end

  // State and output registers; reset drops any burst in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      class_q      <= CUST_STR;
      op_q         <= '0;
      rd_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      insn_valid_q <= 1'b0;
      insn_rdata_q <= '0;
      insn_last_q  <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      class_q      <= class_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      insn_valid_q <= insn_valid_d;
      insn_rdata_q <= insn_rdata_d;
      insn_last_q  <= insn_last_d;
      illegal_q    <= illegal_d;
    end
  end

  assign insn_valid = insn_valid_q;
  assign insn_rdata = insn_rdata_q;
  assign insn_last  = insn_last_q;
  assign illegal_o  = illegal_q;

endmodule

// File: tb/tb_riscv_cust_insn_encoder.sv
// Scoreboard bench for riscv_cust_insn_encoder with directed, hand-computed vectors.
module tb_riscv_cust_insn_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_class;
  logic [2:0]  req_op;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [3:0]  req_repeat;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn_rdata;
  logic        insn_last;
  logic        illegal_o;

  riscv_cust_insn_encoder #(.REP_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_class  (req_class),
    .req_op     (req_op),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_repeat (req_repeat),
    .insn_valid (insn_valid),
    .insn_ready (insn_ready),
    .insn_rdata (insn_rdata),
    .insn_last  (insn_last),
    .illegal_o  (illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        last;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc_q[$];
  int   checks       = 0;
  int   failures     = 0;
  int   cyc          = 0;
  int   illegal_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, expv);
    end
  endtask

  task automatic push_exp(input logic last, input logic [31:0] word);
    exp_t e;
    e.last = last;
    e.word = word;
    exp_q.push_back(e);
  endtask

  // Monitor: every consumed word is popped from the scoreboard and compared
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (illegal_o) illegal_seen++;
    if (!rst && insn_valid && insn_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got 0x%08h required none", insn_rdata);
      end else begin
        e = exp_q.pop_front();
        pop_cyc_q.push_back(cyc);
        $display("word 0x%08h last=%0b (required 0x%08h last=%0b)", insn_rdata, insn_last, e.word, e.last);
        chk("word", insn_rdata, e.word);
        chk("last", {31'd0, insn_last}, {31'd0, e.last});
      end
    end
  end

  // Drive one request and wait (bounded) for it to be accepted; returns at posedge+1
  task automatic send(input logic cls, input logic [2:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [3:0] rep);
    int   n;
    logic acc;
    req_valid  = 1'b1;
    req_class  = cls;
    req_op     = op;
    req_rd     = rd;
    req_rs1    = rs1;
    req_rs2    = rs2;
    req_repeat = rep;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    req_valid  = 1'b0;
    req_rd     = 5'h1f;
    req_rs1    = 5'h1f;
    req_rs2    = 5'h1f;
    req_op     = 3'h5;
    req_repeat = 4'hf;
    $display("req class=%0d op=%0d rd=%0d rs1=%0d rs2=%0d rep=%0d accepted=%0b",
             cls, op, rd, rs1, rs2, rep, acc);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL req_accept: got timeout required accept");
    end
  endtask

  // Wait (bounded) until the scoreboard is empty and the output is idle
  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || insn_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
  endtask

  initial begin
    int d;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_class  = 1'b0;
    req_op     = 3'd0;
    req_rd     = 5'd0;
    req_rs1    = 5'd0;
    req_rs2    = 5'd0;
    req_repeat = 4'd0;
    insn_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, insn_valid}, 32'd0);
    chk("rst_rdata", insn_rdata, 32'd0);
    chk("rst_last", {31'd0, insn_last}, 32'd0);
    chk("rst_illegal", {31'd0, illegal_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

    // 1: STR UPPER single word, valid one cycle after accept
    insn_ready = 1'b1;
    push_exp(1'b1, 32'h0003028B);
    send(1'b0, 3'd0, 5'd5, 5'd6, 5'd0, 4'd0);
    chk("t1_latency_valid", {31'd0, insn_valid}, 32'd1);
    chk("t1_last", {31'd0, insn_last}, 32'd1);
    wait_drain();

    // 2: MAC CON_OP held under backpressure for 3 cycles
    insn_ready = 1'b0;
    push_exp(1'b1, 32'h00C5A52B);
    send(1'b1, 3'd2, 5'd10, 5'd11, 5'd12, 4'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", {31'd0, insn_valid}, 32'd1);
      chk("t2_hold_rdata", insn_rdata, 32'h00C5A52B);
      chk("t2_hold_last", {31'd0, insn_last}, 32'd1);
      chk("t2_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    insn_ready = 1'b1;
    wait_drain();

    // 3: MAC_OP burst of 3 with index wrap 31 -> 1
    push_exp(1'b0, 32'h001F8F2B);
    push_exp(1'b0, 32'h00108FAB);
    push_exp(1'b1, 32'h001100AB);
    send(1'b1, 3'd0, 5'd30, 5'd31, 5'd1, 4'd2);
    wait_drain();

    // 4: illegal STR op and illegal MAC op
    send(1'b0, 3'd4, 5'd1, 5'd2, 5'd3, 4'd0);
    chk("t4a_illegal", {31'd0, illegal_o}, 32'd1);
    chk("t4a_no_valid", {31'd0, insn_valid}, 32'd0);
    chk("t4a_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("t4a_pulse_end", {31'd0, illegal_o}, 32'd0);
    send(1'b1, 3'd7, 5'd1, 5'd2, 5'd3, 4'd0);
    chk("t4b_illegal", {31'd0, illegal_o}, 32'd1);
    chk("t4b_no_valid", {31'd0, insn_valid}, 32'd0);
    chk("t4b_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("t4b_pulse_end", {31'd0, illegal_o}, 32'd0);

    // 5: back-to-back single words, no bubble
    pop_cyc_q.delete();
    push_exp(1'b1, 32'h0031108B);
    push_exp(1'b1, 32'h009463AB);
    send(1'b0, 3'd1, 5'd1, 5'd2, 5'd3, 4'd0);
    send(1'b1, 3'd6, 5'd7, 5'd8, 5'd9, 4'd0);
    wait_drain();
    d = (pop_cyc_q.size() >= 2) ? (pop_cyc_q[1] - pop_cyc_q[0]) : -1;
    chk("t5_gap_cycles", d, 32'd1);

    // 6: reset in the middle of a rep=3 burst, then a normal request
    push_exp(1'b0, 32'h0062A20B);
    send(1'b0, 3'd2, 5'd4, 5'd5, 5'd6, 4'd3);
    chk("t6_word1", insn_rdata, 32'h0062A20B);
    @(posedge clk);
    #1;
    chk("t6_word2", insn_rdata, 32'h0063228B);
    chk("t6_word2_last", {31'd0, insn_last}, 32'd0);
    insn_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_valid", {31'd0, insn_valid}, 32'd0);
    chk("t6_rst_rdata", insn_rdata, 32'd0);
    chk("t6_rst_last", {31'd0, insn_last}, 32'd0);
    chk("t6_rst_illegal", {31'd0, illegal_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    insn_ready = 1'b1;
    push_exp(1'b1, 32'h0003028B);
    send(1'b0, 3'd0, 5'd5, 5'd6, 5'd0, 4'd0);
    wait_drain();

    repeat (2) @(posedge clk);
    #1;
    chk("illegal_pulses", illegal_seen, 32'd2);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
